adder_result_fifo: RTL

//  Downstream stage of the 32-bit adder. Captures each {Cout,Sum} result when the producer strobes in_valid.

---
 rtl/adder_pkg.sv | 11 +
 rtl/adder_result_fifo_if.sv | 23 ++
 rtl/adder_result_fifo_mem.sv | 22 ++
 rtl/adder_result_fifo.sv | 69 ++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Types and constants shared by the adder, its operand driver, the result FIFO and the scoreboard.
package adder_pkg;

  localparam int ADDER_WIDTH = 32;

  typedef struct packed {
    logic                   cout;
    logic [ADDER_WIDTH-1:0] sum;
  } adder_result_t;

endpackage

// File: rtl/adder_result_fifo_if.sv
// Producer/consumer handshake bundle around the adder result FIFO.
interface adder_result_fifo_if #(
  parameter int WIDTH = adder_pkg::ADDER_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport master (
    output in_valid, in_sum, in_cout, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_sum, in_cout, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/adder_result_fifo_mem.sv
// Storage array for the result FIFO: synchronous write, asynchronous read.
module adder_result_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH:0]           rdata
);

  logic [WIDTH:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adder_result_fifo.sv
// First-word-fall-through buffer for adder {Cout,Sum} results with drop and carry counters.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  adder_result_fifo_if.slave     bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       carry_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [WIDTH:0]   head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign bus.in_ready  = (level != FULL_LVL);
  assign bus.out_valid = (level != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  adder_result_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (wr_ptr),
    .wdata ({bus.in_cout, bus.in_sum}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Empty FIFO shows zeros rather than stale storage.
  assign bus.out_sum  = bus.out_valid ? head[WIDTH-1:0] : '0;
  assign bus.out_cout = bus.out_valid ? head[WIDTH]     : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      drop_cnt  <= '0;
      carry_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
      if (bus.in_valid && !bus.in_ready) drop_cnt  <= sat_inc(drop_cnt);
      if (push && bus.in_cout)           carry_cnt <= sat_inc(carry_cnt);
    end
  end

endmodule
